// File: rtl/bcd_display_scan_if.sv
// ---------------------------------------------------------------------------
// bcd_display_scan_if
//
// Bundle between the binary-to-BCD encoder side and the 3-digit multiplexed
// 7-segment driver.
//
// Handshake: `valid` qualifies `bcd` on every rising edge. There is no ready
// and no backpressure, so every edge that sees valid=1 is one capture attempt.
// A new word may be offered every cycle.
//
// Signals
//   bcd       [9:0]  packed BCD word: [9:8] hundreds, [7:4] tens, [3:0] ones
//   valid            qualifier for bcd
//   seg       [6:0]  segment pattern {g,f,e,d,c,b,a}, active-high
//   an        [2:0]  one-hot digit enable: [0] ones, [1] tens, [2] hundreds
//   err              one-cycle pulse after a rejected (non-BCD) capture
//   dbg_state        scan FSM state (0 = IDLE, 1 = SCAN), observation only
//
// Modports
//   master : word producer / display observer
//   slave  : the display driver
// ---------------------------------------------------------------------------
interface bcd_display_scan_if;
    logic [9:0] bcd;
    logic       valid;
    logic [6:0] seg;
    logic [2:0] an;
    logic       err;
    logic       dbg_state;

    modport master (
        output bcd,
        output valid,
        input  seg,
        input  an,
        input  err,
        input  dbg_state
    );

    modport slave (
        input  bcd,
        input  valid,
        output seg,
        output an,
        output err,
        output dbg_state
    );
endinterface

// File: rtl/bcd_display_scan.sv
// ---------------------------------------------------------------------------
// bcd_display_scan
//
// 3-digit multiplexed 7-segment driver. It latches each legal packed BCD word
// and time-multiplexes the ones, tens and hundreds digits onto one shared
// segment bus. Each digit is held for CLK_DIV cycles, and a full frame takes
// 3*CLK_DIV cycles.
//
// Parameters
//   CLK_DIV  cycles each digit is held (>= 2)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bcd_display_scan_if.slave (bcd/valid in; seg/an/err/dbg_state out)
//
// Build option
//   BCD_LZB_EN  when defined, leading zeros are blanked. The hundreds slot is
//               dark when hundreds==0. The tens slot is dark when hundreds and
//               tens are both 0. A dark slot still uses its CLK_DIV cycles.
//               The ones digit is always shown.
//
// Timing
//   A capture at edge T updates disp_reg at T. seg/an reflect it from T+1.
//   A rejected capture at T raises err from T+1 to T+2.
//   Reset clears every output immediately.
// ---------------------------------------------------------------------------
module bcd_display_scan #(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_display_scan_if.slave  bus
);

    // Prescaler width. Keep at least one bit so the declaration stays legal
    // even for degenerate parameter values.
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [9:0]      disp_reg;
    logic [PW-1:0]   presc_q;
    logic [1:0]      idx_q;      // 0 = ones, 1 = tens, 2 = hundreds
    logic            err_pend_q; // rejected capture seen on the previous edge

    logic            legal;
    logic            cap_ok;
    logic            cap_bad;
    logic            wrap;

    logic [6:0]      seg_d;
    logic [2:0]      an_d;
    logic [6:0]      seg_q;
    logic [2:0]      an_q;
    logic            err_q;

    // ------------------------------------------------------------------
    // Capture qualification
    // ------------------------------------------------------------------
    assign legal   = (bus.bcd[9:8] <= 2'd2) &&
                     (bus.bcd[7:4] <= 4'd9) &&
                     (bus.bcd[3:0] <= 4'd9);
    assign cap_ok  = bus.valid &  legal;
    assign cap_bad = bus.valid & ~legal;

    // ------------------------------------------------------------------
    // Scan FSM: IDLE until the first legal word, then SCAN until reset.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cap_ok) state_d = SCAN;
            SCAN:    state_d = SCAN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Display register. A capture never touches the prescaler or the
    // index, so the scan phase stays undisturbed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_reg <= '0;
        end else if (cap_ok) begin
            disp_reg <= bus.bcd;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and digit index. Both count only while in SCAN. On the
    // edge that leaves IDLE they are still 0, so the ones digit gets a
    // full CLK_DIV-cycle slot first.
    // ------------------------------------------------------------------
    assign wrap = (presc_q == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
        end else if (state_q == SCAN) begin
            if (wrap) begin
                presc_q <= '0;
                idx_q   <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end else begin
            presc_q <= '0;
            idx_q   <= 2'd0;
        end
    end

    // ------------------------------------------------------------------
    // Rejected capture: two register stages, so err lines up with the
    // one-cycle display latency.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pend_q <= 1'b0;
        end else begin
            err_pend_q <= cap_bad;
        end
    end

    // ------------------------------------------------------------------
    // Digit decode
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Next output pattern, built from the current index and display word.
    // The output registers add the single cycle of latency.
    always_comb begin
        logic [3:0] digit;
        logic [2:0] onehot;
        logic       blank;

        seg_d  = 7'h00;
        an_d   = 3'b000;
        digit  = 4'd0;
        onehot = 3'b000;
        blank  = 1'b0;

        if (state_q == SCAN) begin
            case (idx_q)
                2'd0: begin
                    digit  = disp_reg[3:0];
                    onehot = 3'b001;
                end
                2'd1: begin
                    digit  = disp_reg[7:4];
                    onehot = 3'b010;
`ifdef BCD_LZB_EN
                    blank  = (disp_reg[9:8] == 2'd0) && (disp_reg[7:4] == 4'd0);
`else
                    blank  = 1'b0;
`endif
                end
                2'd2: begin
                    digit  = {2'b00, disp_reg[9:8]};
                    onehot = 3'b100;
`ifdef BCD_LZB_EN
                    blank  = (disp_reg[9:8] == 2'd0);
`else
                    blank  = 1'b0;
`endif
                end
                default: begin
                    digit  = 4'd0;
                    onehot = 3'b000;
                end
            endcase

            if (!blank) begin
                seg_d = seg_decode(digit);
                an_d  = onehot;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 7'h00;
            an_q  <= 3'b000;
            err_q <= 1'b0;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
            err_q <= err_pend_q;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.an        = an_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = (state_q == SCAN);

endmodule

// File: tb/tb_bcd_display_scan.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_scan
//
// Directed bench for bcd_display_scan with CLK_DIV=4. Each step pushes the
// expected {an, seg, err} for every upcoming cycle. After each rising edge,
// the bench pops one entry and compares it with the outputs.
// ---------------------------------------------------------------------------
module tb_bcd_display_scan;

    localparam int DIV = 4;
    localparam int W   = 11;   // {an[2:0], seg[6:0], err}

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bcd_display_scan_if bus_if ();

    bcd_display_scan #(.CLK_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    logic [W-1:0] exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           k       = 0;   // cycles since the capture that started scanning

    // Reference segment table
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Expected output after edge kk of the scan. That output shows the slot
    // that was active during cycle kk-1.
    function automatic logic [W-1:0] scan_word(input int kk, input logic [1:0] h,
                                               input logic [3:0] t, input logic [3:0] o,
                                               input logic e);
        int         slot;
        logic [2:0] a;
        logic [6:0] s;
        logic       blank;
        slot  = ((kk - 1) / DIV) % 3;
        blank = 1'b0;
        case (slot)
            0: begin a = 3'b001; s = seg_of(o); end
            1: begin
                a = 3'b010; s = seg_of(t);
`ifdef BCD_LZB_EN
                blank = (h == 2'd0) && (t == 4'd0);
`endif
            end
            default: begin
                a = 3'b100; s = seg_of({2'b00, h});
`ifdef BCD_LZB_EN
                blank = (h == 2'd0);
`endif
            end
        endcase
        if (blank) begin
            a = 3'b000;
            s = 7'h00;
        end
        return {a, s, e};
    endfunction

    task automatic push_idle(input int n, input logic e);
        for (int i = 0; i < n; i++) exp_q.push_back({10'b0, e});
    endtask

    task automatic push_scan(input int n, input logic [1:0] h, input logic [3:0] t,
                             input logic [3:0] o, input logic e);
        for (int i = 0; i < n; i++) begin
            k = k + 1;
            exp_q.push_back(scan_word(k, h, t, o, e));
        end
    endtask

    task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed an=%b seg=%h err=%b, expected an=%b seg=%h err=%b",
                   tag, obs[10:8], obs[7:1], obs[0], exp[10:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic check_state(input string tag, input logic exp);
        n_tests++;
        assert (bus_if.dbg_state === exp) else begin
            n_fail++;
            $error("FAIL %s: observed dbg_state=%b, expected %b", tag, bus_if.dbg_state, exp);
        end
    endtask

    task automatic tick(input string tag);
        logic [W-1:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard, expected a pending entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_word(tag, {bus_if.an, bus_if.seg, bus_if.err}, e);
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic drive(input logic v, input logic [9:0] w);
        bus_if.valid = v;
        bus_if.bcd   = w;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed no end of run by 50000ns, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b0, 10'd0);
        rst_n = 1'b0;
        #2;
        check_word("reset_outputs", {bus_if.an, bus_if.seg, bus_if.err}, '0);
        check_state("reset_state", 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Dark while idle
        push_idle(20, 1'b0);
        run(20, "idle_dark");
        check_state("idle_state", 1'b0);

        // Capture 255; two full frames
        drive(1'b1, 10'b10_0101_0101);
        push_idle(1, 1'b0);
        tick("cap255_edge");
        drive(1'b0, 10'd0);
        k = 0;
        push_scan(24, 2'd2, 4'd5, 4'd5, 1'b0);
        run(24, "frame255");
        check_state("scan_state", 1'b1);

        // Illegal tens digit: err for one cycle, display unchanged
        drive(1'b1, 10'b10_1010_0101);
        push_scan(1, 2'd2, 4'd5, 4'd5, 1'b0);
        tick("bad_edge");
        drive(1'b0, 10'd0);
        push_scan(1, 2'd2, 4'd5, 4'd5, 1'b1);
        tick("err_pulse");
        push_scan(4, 2'd2, 4'd5, 4'd5, 1'b0);
        run(4, "err_after");

        // Capture 138 inside the tens slot
        while ((k % 12) != 5) begin
            push_scan(1, 2'd2, 4'd5, 4'd5, 1'b0);
            tick("align_tens");
        end
        drive(1'b1, {2'd1, 4'd3, 4'd8});
        push_scan(1, 2'd2, 4'd5, 4'd5, 1'b0);
        tick("t138_edge");
        drive(1'b0, 10'd0);
        push_scan(14, 2'd1, 4'd3, 4'd8, 1'b0);
        run(14, "show138");

        // Back-to-back words: 123, 246, then illegal (hundreds 3)
        drive(1'b1, {2'd1, 4'd2, 4'd3});
        push_scan(1, 2'd1, 4'd3, 4'd8, 1'b0);
        tick("b2b_first");
        drive(1'b1, {2'd2, 4'd4, 4'd6});
        push_scan(1, 2'd1, 4'd2, 4'd3, 1'b0);
        tick("b2b_second");
        drive(1'b1, 10'b11_0000_0000);
        push_scan(1, 2'd2, 4'd4, 4'd6, 1'b0);
        tick("b2b_bad");
        drive(1'b0, 10'd0);
        push_scan(1, 2'd2, 4'd4, 4'd6, 1'b1);
        tick("b2b_err");
        push_scan(12, 2'd2, 4'd4, 4'd6, 1'b0);
        run(12, "show246");

        // Capture 007 on the same edge as the digit advance
        while ((k % 12) != 11) begin
            push_scan(1, 2'd2, 4'd4, 4'd6, 1'b0);
            tick("align_wrap");
        end
        drive(1'b1, {2'd0, 4'd0, 4'd7});
        push_scan(1, 2'd2, 4'd4, 4'd6, 1'b0);
        tick("t007_edge");
        drive(1'b0, 10'd0);
        push_scan(24, 2'd0, 4'd0, 4'd7, 1'b0);
        run(24, "show007");
        push_scan(2, 2'd0, 4'd0, 4'd7, 1'b0);
        run(2, "pre_reset");

        // Async reset mid-scan: outputs clear before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        check_word("async_reset", {bus_if.an, bus_if.seg, bus_if.err}, '0);
        check_state("async_reset_state", 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(10, 1'b0);
        run(10, "post_reset_dark");

        // Illegal word while idle: err only, stays dark
        drive(1'b1, 10'b00_0000_1100);
        push_idle(1, 1'b0);
        tick("idle_bad_edge");
        drive(1'b0, 10'd0);
        push_idle(1, 1'b1);
        tick("idle_err");
        push_idle(4, 1'b0);
        run(4, "idle_after_err");
        check_state("idle_after_bad", 1'b0);

        // Legal 209 restarts scanning from the ones digit
        drive(1'b1, {2'd2, 4'd0, 4'd9});
        push_idle(1, 1'b0);
        tick("cap209_edge");
        drive(1'b0, 10'd0);
        k = 0;
        push_scan(12, 2'd2, 4'd0, 4'd9, 1'b0);
        run(12, "frame209");
        check_state("rescan_state", 1'b1);

        n_tests++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
